// File: rtl/vdp_audio_pkg.sv
// Shared definitions for the ADC audio path: state encoding, PCM width and
// the 16-bit saturation helper.
package vdp_audio_pkg;

  localparam int PCM_W = 16;

  typedef enum logic [1:0] {
    AC_IDLE,
    AC_RUN,
    AC_MUTE
  } adc_cond_state_t;

  function automatic logic signed [PCM_W-1:0] sat16(input logic signed [16:0] v);
    if (v > 17'sd32767) begin
      return 16'sh7fff;
    end
    if (v < -17'sd32768) begin
      return 16'sh8000;
    end
    return $signed(v[15:0]);
  endfunction

endpackage

// File: rtl/adc_dc_blocker.sv
// Stage A: offset-binary to signed 16-bit conversion and first-order IIR DC
// removal, producing one high-passed sample per accepted ADC strobe.
module adc_dc_blocker
  import vdp_audio_pkg::*;
#(
  parameter int DC_SHIFT = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    accept,
  input  logic [11:0]             adc_data,
  output logic signed [PCM_W-1:0] hp_data,
  output logic                    hp_v
);

  localparam int ACC_W = PCM_W + DC_SHIFT + 1;

  logic signed [ACC_W-1:0] dc_acc_q, dc_acc_d;
  logic signed [PCM_W-1:0] hp_q, hp_d;
  logic                    hp_v_q, hp_v_d;
  logic signed [PCM_W-1:0] x16;
  logic signed [16:0]      dc;
  logic signed [16:0]      diff;

  always_comb begin
    // Flipping the MSB maps offset-binary mid-scale onto zero.
    x16      = $signed({~adc_data[11], adc_data[10:0], 4'b0000});
    dc       = 17'(dc_acc_q >>> DC_SHIFT);
    diff     = 17'(x16) - dc;
    dc_acc_d = dc_acc_q;
    hp_d     = hp_q;
    hp_v_d   = 1'b0;
    if (clear) begin
      dc_acc_d = '0;
      hp_d     = '0;
    end else if (accept) begin
      hp_d     = sat16(diff);
      hp_v_d   = 1'b1;
      dc_acc_d = dc_acc_q + ACC_W'(x16) - ACC_W'(dc);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dc_acc_q <= '0;
      hp_q     <= '0;
      hp_v_q   <= 1'b0;
    end else begin
      dc_acc_q <= dc_acc_d;
      hp_q     <= hp_d;
      hp_v_q   <= hp_v_d;
    end
  end

  assign hp_data = hp_q;
  assign hp_v    = hp_v_q;

endmodule

// File: rtl/adc_audio_conditioner.sv
// MCP3202 sample conditioner: DC blocker, boxcar decimator and a dropout
// watchdog that mutes the PCM output when the ADC stops strobing.
module adc_audio_conditioner
  import vdp_audio_pkg::*;
#(
  parameter int DECIM_LOG2     = 2,
  parameter int DC_SHIFT       = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [11:0]             adc_data,
  input  logic                    adc_valid,
  output logic signed [PCM_W-1:0] pcm_out,
  output logic                    pcm_valid,
  output logic                    adc_alive
);

  localparam int SUM_W = PCM_W + DECIM_LOG2;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_SAT  = WD_W'(TIMEOUT_CYCLES);

  adc_cond_state_t         state_q, state_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic signed [SUM_W-1:0] acc_q, acc_d;
  logic [DECIM_LOG2-1:0]   count_q, count_d;
  logic signed [PCM_W-1:0] pcm_out_q, pcm_out_d;
  logic                    pcm_valid_q, pcm_valid_d;
  logic                    alive_q, alive_d;

  logic                    accept;
  logic                    blk_clear;
  logic signed [PCM_W-1:0] hp_data;
  logic                    hp_v;
  logic signed [SUM_W-1:0] sum;
  logic signed [PCM_W-1:0] avg;

  assign accept    = adc_valid & enable;
  assign blk_clear = ~enable;

  adc_dc_blocker #(
    .DC_SHIFT (DC_SHIFT)
  ) u_dc_blocker (
    .clk      (clk),
    .reset    (reset),
    .clear    (blk_clear),
    .accept   (accept),
    .adc_data (adc_data),
    .hp_data  (hp_data),
    .hp_v     (hp_v)
  );

  // The group mean of 16-bit samples always fits 16 bits, so plain truncation is safe.
  assign sum = acc_q + SUM_W'(hp_data);
  assign avg = PCM_W'(sum >>> DECIM_LOG2);

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    acc_d       = acc_q;
    count_d     = count_q;
    pcm_out_d   = pcm_out_q;
    pcm_valid_d = 1'b0;
    if (!enable) begin
      state_d   = AC_IDLE;
      wd_d      = '0;
      acc_d     = '0;
      count_d   = '0;
      pcm_out_d = '0;
    end else begin
      if (hp_v) begin
        if (count_q == '1) begin
          pcm_out_d   = avg;
          pcm_valid_d = 1'b1;
          acc_d       = '0;
          count_d     = '0;
        end else begin
          acc_d   = sum;
          count_d = count_q + 1'b1;
        end
      end
      // An accepted sample always wins over an expiring watchdog.
      if (accept) begin
        state_d = AC_RUN;
        wd_d    = '0;
      end else begin
        case (state_q)
          AC_IDLE: begin
            state_d = AC_RUN;
            wd_d    = '0;
          end
          AC_RUN: begin
            if (wd_q >= WD_LAST) begin
              state_d     = AC_MUTE;
              wd_d        = WD_SAT;
              acc_d       = '0;
              count_d     = '0;
              pcm_out_d   = '0;
              pcm_valid_d = 1'b0;
            end else begin
              wd_d = wd_q + 1'b1;
            end
          end
          AC_MUTE: begin
            state_d = AC_MUTE;
          end
          default: begin
            state_d = AC_IDLE;
          end
        endcase
      end
    end
    alive_d = (state_d == AC_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= AC_IDLE;
      wd_q        <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      pcm_out_q   <= '0;
      pcm_valid_q <= 1'b0;
      alive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      pcm_out_q   <= pcm_out_d;
      pcm_valid_q <= pcm_valid_d;
      alive_q     <= alive_d;
    end
  end

  assign pcm_out   = pcm_out_q;
  assign pcm_valid = pcm_valid_q;
  assign adc_alive = alive_q;

endmodule

// File: tb/tb_adc_audio_conditioner.sv
// Self-checking bench for adc_audio_conditioner: a per-sample behavioural
// model compared every cycle, plus directed scenarios with literal expectations.
module tb_adc_audio_conditioner;

  localparam int DECIM_LOG2     = 2;
  localparam int DC_SHIFT       = 10;
  localparam int TIMEOUT_CYCLES = 4096;
  localparam int GRP            = 1 << DECIM_LOG2;
  localparam int M_IDLE = 0, M_RUN = 1, M_MUTE = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic               adc_valid = 1'b0;
  logic [11:0]        adc_data = 12'h000;
  logic signed [15:0] pcm_out;
  logic               pcm_valid;
  logic               adc_alive;

  int n_pass  = 0;
  int n_total = 0;
  int pv_count = 0;

  // Behavioural model state
  longint m_dc;
  longint m_grp[$];
  longint hp_log[$];
  bit     m_hp_pend;
  longint m_hp_val;
  int     m_since;
  int     m_mode;
  longint m_pcm;
  bit     m_pv;
  bit     m_alive;

  adc_audio_conditioner #(
    .DECIM_LOG2     (DECIM_LOG2),
    .DC_SHIFT       (DC_SHIFT),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .pcm_out   (pcm_out),
    .pcm_valid (pcm_valid),
    .adc_alive (adc_alive)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_eq(input string name, input longint act, input longint exp);
    chk(name, act == exp, act, exp);
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_clear();
    m_dc      = 0;
    m_grp.delete();
    m_hp_pend = 0;
    m_hp_val  = 0;
    m_since   = 0;
    m_mode    = M_IDLE;
    m_pcm     = 0;
    m_pv      = 0;
    m_alive   = 0;
  endtask

  // One clock edge of the reference: samples are full-scale ADC codes minus
  // mid-scale, scaled by 16; averaging is a floored mean over each group.
  task automatic model_step();
    longint x, dc, sum;
    if (reset || !enable) begin
      model_clear();
      return;
    end
    m_pv = 0;
    if (m_hp_pend) begin
      m_grp.push_back(m_hp_val);
      if (m_grp.size() == GRP) begin
        sum = 0;
        foreach (m_grp[i]) sum += m_grp[i];
        m_pcm = floor_div(sum, GRP);
        m_pv  = 1;
        m_grp.delete();
      end
    end
    m_hp_pend = 0;
    if (adc_valid) begin
      x  = (longint'(adc_data) - 2048) * 16;
      dc = floor_div(m_dc, longint'(1) << DC_SHIFT);
      m_hp_val  = clamp16(x - dc);
      m_hp_pend = 1;
      m_dc      = m_dc + x - dc;
      hp_log.push_back(m_hp_val);
      m_mode  = M_RUN;
      m_since = 0;
    end else if (m_mode == M_IDLE) begin
      m_mode  = M_RUN;
      m_since = 0;
    end else if (m_mode == M_RUN) begin
      m_since++;
      if (m_since >= TIMEOUT_CYCLES) begin
        m_mode = M_MUTE;
        m_pcm  = 0;
        m_pv   = 0;
        m_grp.delete();
      end
    end
    m_alive = (m_mode == M_RUN);
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk_eq("cyc_pcm_out", longint'(pcm_out), m_pcm);
    chk_eq("cyc_pcm_valid", longint'(pcm_valid), longint'(m_pv));
    chk_eq("cyc_adc_alive", longint'(adc_alive), longint'(m_alive));
    if (pcm_valid) pv_count++;
  end

  task automatic strobe(input logic [11:0] d);
    @(negedge clk);
    adc_valid = 1'b1;
    adc_data  = d;
    @(negedge clk);
    adc_valid = 1'b0;
  endtask

  initial begin
    longint mag;
    model_clear();
    #1;
    chk_eq("rst_pcm_out", longint'(pcm_out), 0);
    chk_eq("rst_pcm_valid", longint'(pcm_valid), 0);
    chk_eq("rst_adc_alive", longint'(adc_alive), 0);
    repeat (3) @(negedge clk);

    // Reset asserted while a pcm_valid strobe is live
    reset  = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) strobe(12'($urandom));
    @(posedge clk);
    #2;
    chk_eq("t1_strobe_live", longint'(pcm_valid), 1);
    reset = 1'b1;
    #1;
    chk_eq("t1_async_pcm_out", longint'(pcm_out), 0);
    chk_eq("t1_async_pcm_valid", longint'(pcm_valid), 0);
    chk_eq("t1_async_adc_alive", longint'(adc_alive), 0);
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    adc_valid = 1'b1;
    adc_data  = 12'h9ab;
    @(posedge clk);
    #1;
    chk_eq("t1_alive_after_first", longint'(adc_alive), 1);
    @(negedge clk);
    adc_valid = 1'b0;

    // Full-scale positive input from a clean reset
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hp_log.delete();
    for (int i = 0; i < 4; i++) strobe(12'hfff);
    chk_eq("t2_hp_count", hp_log.size(), 4);
    chk_eq("t2_hp0", hp_log[0], 32752);
    chk_eq("t2_hp1", hp_log[1], 32721);
    chk_eq("t2_hp2", hp_log[2], 32689);
    chk_eq("t2_hp3", hp_log[3], 32657);
    chk_eq("t2_no_early_valid", longint'(pcm_valid), 0);
    @(posedge clk);
    #1;
    chk_eq("t2_valid", longint'(pcm_valid), 1);
    chk_eq("t2_pcm_out", longint'(pcm_out), 32704);
    @(posedge clk);
    #1;
    chk_eq("t2_valid_one_cycle", longint'(pcm_valid), 0);

    // Constant input: the DC tracker must remove it
    for (int i = 0; i < 8000; i++) strobe(12'ha00);
    @(posedge clk);
    #1;
    mag = (pcm_out < 0) ? -longint'(pcm_out) : longint'(pcm_out);
    chk("t3_dc_removed_abs", mag <= 16, mag, 16);

    // Negative full scale against a positive DC estimate saturates
    for (int i = 0; i < 4; i++) strobe(12'h000);
    @(posedge clk);
    #1;
    chk_eq("t4_valid", longint'(pcm_valid), 1);
    chk_eq("t4_pcm_out", longint'(pcm_out), -32768);

    // Watchdog: strobe on the timeout cycle keeps RUN
    strobe(12'h800);
    repeat (TIMEOUT_CYCLES - 1) @(posedge clk);
    @(negedge clk);
    adc_valid = 1'b1;
    adc_data  = 12'h800;
    @(posedge clk);
    #1;
    chk_eq("t5_valid_on_timeout_keeps_run", longint'(adc_alive), 1);
    @(negedge clk);
    adc_valid = 1'b0;
    repeat (TIMEOUT_CYCLES - 1) @(posedge clk);
    #1;
    chk_eq("t5_alive_before_timeout", longint'(adc_alive), 1);
    @(posedge clk);
    #1;
    chk_eq("t5_alive_at_timeout", longint'(adc_alive), 0);
    chk_eq("t5_pcm_muted", longint'(pcm_out), 0);
    strobe(12'hc00);
    chk_eq("t5_alive_resumed", longint'(adc_alive), 1);
    for (int i = 0; i < 3; i++) strobe(12'hc00);
    chk_eq("t5_no_early_valid", longint'(pcm_valid), 0);
    @(posedge clk);
    #1;
    chk_eq("t5_valid_after_four", longint'(pcm_valid), 1);

    // Back-to-back samples from a cleared block
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable    = 1'b1;
    adc_valid = 1'b1;
    pv_count  = 0;
    for (int i = 0; i < 16; i++) begin
      adc_data = 12'($urandom);
      @(negedge clk);
    end
    adc_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("t6_b2b_strobes", pv_count, 4);

    // Enable dropped mid-group, including a sample in the falling cycle
    pv_count  = 0;
    adc_valid = 1'b1;
    adc_data  = 12'h345;
    @(negedge clk);
    adc_data = 12'hcde;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    adc_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk_eq("t6_no_strobe_after_drop", pv_count, 0);
    enable    = 1'b1;
    adc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      adc_data = 12'($urandom);
      @(negedge clk);
    end
    adc_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("t6_strobe_after_reenable", pv_count, 1);

    // Randomised traffic with occasional enable drops
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      enable    = ($urandom_range(0, 99) != 0);
      adc_valid = 1'($urandom_range(0, 1));
      adc_data  = 12'($urandom);
    end
    @(negedge clk);
    enable    = 1'b1;
    adc_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
